// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the pipelined ALU: opcodes, B-operand select,
// FSM states and flag bit positions.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MULT = 4'd2,
        OP_SHL  = 4'd3,
        OP_SHR  = 4'd4,
        OP_ROL  = 4'd5,
        OP_ROR  = 4'd6,
        OP_NOT  = 4'd7,
        OP_AND  = 4'd8,
        OP_OR   = 4'd9,
        OP_XOR  = 4'd10,
        OP_NAND = 4'd11,
        OP_NOR  = 4'd12,
        OP_XNOR = 4'd13,
        OP_INC  = 4'd14,
        OP_DEC  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        MOVI_REG_B = 2'b00,
        MOVI_MEM   = 2'b01,
        MOVI_IMM   = 2'b10,
        MOVI_RSVD  = 2'b11
    } movi_t;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_WAIT = 1'b1
    } fsm_state_t;

    localparam int FLAG_W = 4;
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam int PIPE_STAGES_MIN = 1;
    localparam int PIPE_STAGES_MAX = 4;

endpackage

// File: rtl/alu_pipe_if.sv
// Transaction-in / memory-operand / result-out bundle of the pipelined ALU.
// master = driver/consumer side, slave = the ALU.
interface alu_pipe_if #(parameter int DATA_WIDTH = 8);

    logic                  ACT;
    logic                  ALU_RDY;
    logic [3:0]            OP;
    logic [1:0]            MOVI;
    logic [DATA_WIDTH-1:0] REG_A;
    logic [DATA_WIDTH-1:0] REG_B;
    logic [DATA_WIDTH-1:0] IMM;
    logic                  MEM_REQ;
    logic                  MEM_VLD;
    logic [DATA_WIDTH-1:0] MEM;
    logic [DATA_WIDTH-1:0] EX_ALU;
    logic                  EX_ALU_VLD;
    logic                  EX_ALU_RDY;
    logic [3:0]            EX_FLAGS;

    modport master (
        output ACT, OP, MOVI, REG_A, REG_B, IMM, MEM_VLD, MEM, EX_ALU_RDY,
        input  ALU_RDY, MEM_REQ, EX_ALU, EX_ALU_VLD, EX_FLAGS
    );

    modport slave (
        input  ACT, OP, MOVI, REG_A, REG_B, IMM, MEM_VLD, MEM, EX_ALU_RDY,
        output ALU_RDY, MEM_REQ, EX_ALU, EX_ALU_VLD, EX_FLAGS
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: (op, a, b) -> result and {V,N,Z,C} flags.
// Shifts and rotates move a_i by one bit; b_i is ignored for unary ops.
module alu_core import alu_pipe_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  alu_op_t               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [FLAG_W-1:0]     flags_o
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0]     sum, diff, inc, dec;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0]   res;
    logic                    carry, ovf;

    // The extra top bit is the carry out / borrow.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    assign inc  = {1'b0, a_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign dec  = {1'b0, a_i} - {{DATA_WIDTH{1'b0}}, 1'b1};
    assign prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op_i)
            OP_ADD:  begin res = sum[MSB:0];  carry = sum[DATA_WIDTH];
                           ovf = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]); end
            OP_SUB:  begin res = diff[MSB:0]; carry = diff[DATA_WIDTH];
                           ovf = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]); end
            OP_MULT: begin res = prod[MSB:0]; carry = |prod[2*DATA_WIDTH-1:DATA_WIDTH]; end
            OP_SHL:  begin res = {a_i[MSB-1:0], 1'b0};     carry = a_i[MSB]; end
            OP_SHR:  begin res = {1'b0, a_i[MSB:1]};       carry = a_i[0];   end
            OP_ROL:  begin res = {a_i[MSB-1:0], a_i[MSB]}; carry = a_i[MSB]; end
            OP_ROR:  begin res = {a_i[0], a_i[MSB:1]};     carry = a_i[0];   end
            OP_NOT:  res = ~a_i;
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_NAND: res = ~(a_i & b_i);
            OP_NOR:  res = ~(a_i | b_i);
            OP_XNOR: res = ~(a_i ^ b_i);
            OP_INC:  begin res = inc[MSB:0]; carry = inc[DATA_WIDTH];
                           ovf = !a_i[MSB] && res[MSB]; end
            OP_DEC:  begin res = dec[MSB:0]; carry = dec[DATA_WIDTH];
                           ovf = a_i[MSB] && !res[MSB]; end
        endcase
        flags_o         = '0;
        flags_o[FLAG_C] = carry;
        flags_o[FLAG_Z] = ~|res;
        flags_o[FLAG_N] = res[MSB];
        flags_o[FLAG_V] = ovf;
    end

    assign result_o = res;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: accept FSM with memory-operand fetch, operand mux, and a
// valid/data shift pipeline that freezes as a whole under output backpressure.
module alu_pipe import alu_pipe_pkg::*; #(
    parameter int DATA_WIDTH  = 8,
    parameter int PIPE_STAGES = 2
) (
    input logic       CLK,
    input logic       RST,
    alu_pipe_if.slave bus
);

    localparam int STAGES = (PIPE_STAGES < PIPE_STAGES_MIN) ? PIPE_STAGES_MIN :
                            (PIPE_STAGES > PIPE_STAGES_MAX) ? PIPE_STAGES_MAX : PIPE_STAGES;
    localparam int LAST   = STAGES - 1;

    typedef struct packed {
        logic                  vld;
        logic [DATA_WIDTH-1:0] res;
        logic [FLAG_W-1:0]     flags;
    } stage_t;

    fsm_state_t            state_q;
    alu_op_t               op_q;
    logic [DATA_WIDTH-1:0] a_q;
    stage_t                pipe_q [STAGES];
    stage_t                stage_in_d;

    movi_t                 movi;
    alu_op_t               core_op;
    logic [DATA_WIDTH-1:0] core_a, core_b, core_res;
    logic [FLAG_W-1:0]     core_flags;
    logic                  stall, accept, mem_take, entry_vld;

    assign stall       = pipe_q[LAST].vld && !bus.EX_ALU_RDY;
    assign bus.ALU_RDY = (state_q == S_IDLE) && !stall && !RST;
    assign bus.MEM_REQ = (state_q == S_MEM_WAIT) && !stall;
    assign accept      = bus.ACT && bus.ALU_RDY;
    assign mem_take    = bus.MEM_REQ && bus.MEM_VLD;

    // Stage-1 source: live inputs in IDLE, latched A/OP plus MEM while waiting.
    always_comb begin
        movi      = movi_t'(bus.MOVI);
        core_op   = alu_op_t'(bus.OP);
        core_a    = bus.REG_A;
        core_b    = (movi == MOVI_IMM) ? bus.IMM : bus.REG_B;
        entry_vld = accept && (movi != MOVI_MEM);
        if (state_q == S_MEM_WAIT) begin
            core_op   = op_q;
            core_a    = a_q;
            core_b    = bus.MEM;
            entry_vld = mem_take;
        end
        stage_in_d       = '0;
        stage_in_d.vld   = entry_vld;
        stage_in_d.res   = entry_vld ? core_res : '0;
        stage_in_d.flags = entry_vld ? core_flags : '0;
    end

    alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .op_i     (core_op),
        .a_i      (core_a),
        .b_i      (core_b),
        .result_o (core_res),
        .flags_o  (core_flags)
    );

    always_ff @(posedge CLK) begin
        // NOTE: the pipeline data is reset along with the valids because EX_ALU/EX_FLAGS must read 0 out of reset.
        if (RST) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's pre-edge value.
            if (state_q == S_IDLE) begin
                if (accept && movi == MOVI_MEM) begin
                    state_q <= S_MEM_WAIT;
                    op_q    <= alu_op_t'(bus.OP);
                    a_q     <= bus.REG_A;
                end
            end else if (mem_take) begin
                state_q <= S_IDLE;
            end
            if (!stall) begin
                pipe_q[0] <= stage_in_d;
                for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign bus.EX_ALU     = pipe_q[LAST].res;
    assign bus.EX_FLAGS   = pipe_q[LAST].flags;
    assign bus.EX_ALU_VLD = pipe_q[LAST].vld;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (DATA_WIDTH=8, PIPE_STAGES=2): directed vectors,
// an arithmetic reference model with an in-order scoreboard, and literal expectations.
module tb_alu_pipe;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic RST;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [11:0] sb_q[$];
    logic [11:0] out_log[$];
    logic        mem_pending = 1'b0;
    int          pend_op, pend_a;

    alu_pipe_if #(.DATA_WIDTH(W)) bus ();

    alu_pipe #(.DATA_WIDTH(W), .PIPE_STAGES(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, returns {V,N,Z,C,result}.
    function automatic logic [11:0] model(input int op, input int a, input int b);
        int r, s, sa, sb;
        bit c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = 0; s = 0; c = 0; v = 0;
        case (op)
            0:  begin r = a + b; c = (r > 255); s = sa + sb; v = (s > 127 || s < -128); end
            1:  begin r = a - b; c = (a < b);   s = sa - sb; v = (s > 127 || s < -128); end
            2:  begin r = a * b; c = (r > 255); end
            3:  begin r = a * 2; c = (a >= 128); end
            4:  begin r = a / 2; c = (a % 2 == 1); end
            5:  begin r = a * 2 + a / 128; c = (a >= 128); end
            6:  begin r = a / 2 + (a % 2) * 128; c = (a % 2 == 1); end
            7:  r = 255 - a;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a & b);
            12: r = 255 - (a | b);
            13: r = 255 - (a ^ b);
            14: begin r = a + 1; c = (a == 255); v = (sa == 127); end
            15: begin r = a - 1; c = (a == 0);   v = (sa == -128); end
            default: r = 0;
        endcase
        r = ((r % 256) + 256) % 256;
        return {v, (r >= 128), (r == 0), c, 8'(r)};
    endfunction

    // Compare process: inputs and outputs are stable at the falling edge and
    // describe what the next rising edge will do.
    always @(negedge CLK) begin
        if (RST) begin
            sb_q.delete();
            mem_pending = 1'b0;
        end else begin
            check("alu_rdy", 64'(bus.ALU_RDY),
                  64'(!mem_pending && !(bus.EX_ALU_VLD && !bus.EX_ALU_RDY)));
            check("mem_req", 64'(bus.MEM_REQ),
                  64'(mem_pending && !(bus.EX_ALU_VLD && !bus.EX_ALU_RDY)));
            if (bus.EX_ALU_VLD) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 64'(1), 64'(0));
                end else begin
                    check("sb_result", 64'({bus.EX_FLAGS, bus.EX_ALU}), 64'(sb_q[0]));
                    if (bus.EX_ALU_RDY) begin
                        void'(sb_q.pop_front());
                        out_log.push_back({bus.EX_FLAGS, bus.EX_ALU});
                    end
                end
            end
            if (bus.ACT && bus.ALU_RDY) begin
                if (bus.MOVI == 2'b01) begin
                    mem_pending = 1'b1;
                    pend_op     = int'(bus.OP);
                    pend_a      = int'(bus.REG_A);
                end else begin
                    sb_q.push_back(model(int'(bus.OP), int'(bus.REG_A),
                                   int'(bus.MOVI == 2'b10 ? bus.IMM : bus.REG_B)));
                end
            end
            if (bus.MEM_REQ && bus.MEM_VLD) begin
                sb_q.push_back(model(pend_op, pend_a, int'(bus.MEM)));
                mem_pending = 1'b0;
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] movi,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] imm);
        bit granted = 1'b0;
        bus.ACT = 1'b1; bus.OP = op; bus.MOVI = movi;
        bus.REG_A = a; bus.REG_B = b; bus.IMM = imm;
        for (int k = 0; k < 50; k++) begin
            @(negedge CLK);
            if (bus.ALU_RDY) begin granted = 1'b1; break; end
        end
        if (!granted) check("issue_timeout", 64'(0), 64'(1));
        @(posedge CLK); #1;
        bus.ACT = 1'b0;
    endtask

    task automatic wait_result(input string name, input int limit, input logic [11:0] exp);
        bit seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge CLK);
            if (bus.EX_ALU_VLD) begin seen = 1'b1; break; end
        end
        check({name, "_seen"}, 64'(seen), 64'(1));
        if (seen) check(name, 64'({bus.EX_FLAGS, bus.EX_ALU}), 64'(exp));
        @(posedge CLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        int n0;
        RST = 1'b1;
        bus.ACT = 1'b1; bus.OP = 4'd0; bus.MOVI = 2'b00;
        bus.REG_A = '0; bus.REG_B = '0; bus.IMM = '0;
        bus.MEM_VLD = 1'b0; bus.MEM = '0; bus.EX_ALU_RDY = 1'b1;

        // Literal pins on the reference model itself.
        check("model_rol",  64'(model(5, 'h81, 0)),     64'(12'h103));
        check("model_mult", 64'(model(2, 'h10, 'h10)),  64'(12'h300));
        check("model_addv", 64'(model(0, 'h7F, 'h01)),  64'(12'hC80));
        check("model_dec",  64'(model(15, 'h00, 0)),    64'(12'h5FF));

        // Reset for three edges with ACT held high.
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            check("rst_alu_rdy", 64'(bus.ALU_RDY),    64'(0));
            check("rst_vld",     64'(bus.EX_ALU_VLD), 64'(0));
            check("rst_ex_alu",  64'(bus.EX_ALU),     64'(0));
            check("rst_flags",   64'(bus.EX_FLAGS),   64'(0));
            check("rst_mem_req", 64'(bus.MEM_REQ),    64'(0));
        end
        RST = 1'b0; bus.ACT = 1'b0;
        @(negedge CLK);
        check("rdy_after_reset", 64'(bus.ALU_RDY), 64'(1));
        @(posedge CLK); #1;

        // ADD F0+20: invisible after the accept edge, valid one edge later.
        issue(4'd0, 2'b00, 8'hF0, 8'h20, 8'h00);
        @(negedge CLK);
        check("add_latency_early", 64'(bus.EX_ALU_VLD), 64'(0));
        wait_result("add_f0_20", 1, 12'h110);
        idle(2);

        // SUB with memory operand delivered after three waiting cycles.
        issue(4'd1, 2'b01, 8'h05, 8'hAA, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("memwait_req", 64'(bus.MEM_REQ), 64'(1));
            check("memwait_rdy", 64'(bus.ALU_RDY), 64'(0));
            @(posedge CLK); #1;
        end
        bus.MEM_VLD = 1'b1; bus.MEM = 8'h05;
        @(negedge CLK);
        check("memtake_rdy", 64'(bus.ALU_RDY), 64'(0));
        @(posedge CLK); #1;
        bus.MEM_VLD = 1'b0;
        @(negedge CLK);
        check("after_mem_rdy", 64'(bus.ALU_RDY), 64'(1));
        check("after_mem_req", 64'(bus.MEM_REQ), 64'(0));
        @(posedge CLK); #1;
        wait_result("sub_mem", 4, 12'h200);
        idle(2);

        // Four back-to-back ops with a 3-cycle output stall mid-stream.
        n0 = out_log.size();
        fork
            begin
                issue(4'd8,  2'b00, 8'hCC, 8'hAA, 8'h00);
                issue(4'd9,  2'b10, 8'h0F, 8'h00, 8'hF0);
                issue(4'd10, 2'b00, 8'hFF, 8'hFF, 8'h00);
                issue(4'd4,  2'b00, 8'h03, 8'h00, 8'h00);
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 20; k++) begin
                    @(negedge CLK);
                    if (bus.EX_ALU_VLD) begin seen = 1'b1; break; end
                end
                check("stall_first_seen", 64'(seen), 64'(1));
                @(posedge CLK); #1;
                bus.EX_ALU_RDY = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge CLK);
                    check("stall_alu_rdy", 64'(bus.ALU_RDY),    64'(0));
                    check("stall_vld",     64'(bus.EX_ALU_VLD), 64'(1));
                end
                @(posedge CLK); #1;
                bus.EX_ALU_RDY = 1'b1;
            end
        join
        idle(8);
        check("stall_count", 64'(out_log.size() - n0), 64'(4));
        if (out_log.size() - n0 == 4) begin
            check("stall_out0", 64'(out_log[n0]),   64'(12'h488));
            check("stall_out1", 64'(out_log[n0+1]), 64'(12'h4FF));
            check("stall_out2", 64'(out_log[n0+2]), 64'(12'h200));
            check("stall_out3", 64'(out_log[n0+3]), 64'(12'h101));
        end

        // Reset while waiting on memory, with MEM_VLD high in the reset cycle.
        issue(4'd0, 2'b01, 8'h11, 8'h00, 8'h00);
        RST = 1'b1; bus.MEM_VLD = 1'b1; bus.MEM = 8'h22;
        @(posedge CLK); #1;
        RST = 1'b0; bus.MEM_VLD = 1'b0;
        @(negedge CLK);
        check("rst_memwait_req", 64'(bus.MEM_REQ), 64'(0));
        for (int k = 0; k < 5; k++) begin
            check("rst_memwait_novld", 64'(bus.EX_ALU_VLD), 64'(0));
            @(negedge CLK);
        end
        @(posedge CLK); #1;

        // Boundary vectors with literal expectations.
        issue(4'd5,  2'b00, 8'h81, 8'h00, 8'h00); wait_result("rol_81",   4, 12'h103);
        issue(4'd2,  2'b00, 8'h10, 8'h10, 8'h00); wait_result("mult_10",  4, 12'h300);
        issue(4'd0,  2'b10, 8'h7F, 8'h55, 8'h01); wait_result("add_7f01", 4, 12'hC80);
        issue(4'd15, 2'b00, 8'h00, 8'h00, 8'h00); wait_result("dec_00",   4, 12'h5FF);

        // Full-rate sweep of every opcode, checked by the scoreboard.
        for (int op = 0; op < 16; op++) begin
            issue(4'(op), 2'b00, 8'h9C, 8'h35, 8'h5A);
            issue(4'(op), 2'b10, 8'h01, 8'h5A, 8'hFF);
            issue(4'(op), 2'b11, 8'h80, 8'h80, 8'h5A);
        end
        idle(8);
        check("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
